// File: rtl/blink_tick_gen_pkg.sv
// Shared definitions for the LED blink tick generator: debounce state
// encodings, default timing parameters and a width helper.
package blink_tick_gen_pkg;

  typedef enum logic [1:0] {
    ST_UP     = 2'd0,
    ST_CHK_DN = 2'd1,
    ST_DOWN   = 2'd2,
    ST_CHK_UP = 2'd3
  } db_state_e;

  localparam int DEF_CLK_HZ          = 50000000;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_NUM_RATES       = 4;

  // Keeps single-rate builds from producing a zero-width rate index.
  function automatic int rate_width(input int num_rates);
    return (num_rates > 1) ? $clog2(num_rates) : 1;
  endfunction

endpackage

// File: rtl/blink_tick_gen_if.sv
// Board-side signal bundle of the blink tick generator: raw key in,
// tick/press strobes and current rate index out.
interface blink_tick_gen_if #(
  parameter int NUM_RATES = 4
);
  import blink_tick_gen_pkg::*;

  localparam int RATE_W = rate_width(NUM_RATES);

  logic              KEY_N;
  logic              TICK;
  logic              PRESS;
  logic [RATE_W-1:0] RATE_SEL;

  modport master (output KEY_N, input TICK, input PRESS, input RATE_SEL);
  modport slave  (input KEY_N, output TICK, output PRESS, output RATE_SEL);

endinterface

// File: rtl/blink_tick_gen_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser plus debounce FSM that emits
// a one-cycle press pulse once a low level has been stable long enough.
//
//   state     | meaning
//   ST_UP     | key accepted as released
//   ST_CHK_DN | low seen, qualifying the press
//   ST_DOWN   | key accepted as pressed
//   ST_CHK_UP | high seen, qualifying the release
module blink_tick_gen_key_debounce
  import blink_tick_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_set_o,
  output logic press_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  db_state_e       state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      ST_UP: begin
        if (!sync2_q) begin
          state_d = ST_CHK_DN;
          cnt_d   = '0;
        end
      end
      ST_CHK_DN: begin
        if (sync2_q) begin
          state_d = ST_UP;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_DOWN;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      ST_DOWN: begin
        if (sync2_q) begin
          state_d = ST_CHK_UP;
          cnt_d   = '0;
        end
      end
      ST_CHK_UP: begin
        if (!sync2_q) begin
          state_d = ST_DOWN;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_UP;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: state_d = ST_UP;
    endcase
  end

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_UP;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // press_set_o lets the parent act on the same edge that raises press_o.
  assign press_set_o = press_d;
  assign press_o     = press_q;

endmodule

// File: rtl/blink_tick_gen.sv
// Blink timing stage: debounced key steps through NUM_RATES speeds and a
// prescaler emits one TICK per selected period (CLK_HZ >> rate).
module blink_tick_gen
  import blink_tick_gen_pkg::*;
#(
  parameter int CLK_HZ          = DEF_CLK_HZ,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int NUM_RATES       = DEF_NUM_RATES
) (
  input logic             CLOCK_50,
  input logic             RESET,
  blink_tick_gen_if.slave bus
);

  localparam int RATE_W = rate_width(NUM_RATES);
  localparam int CNT_W  = $clog2(CLK_HZ);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(NUM_RATES - 1);

  generate
    if (((CLK_HZ >> (NUM_RATES - 1)) < 2) || (DEBOUNCE_CYCLES < 2)) begin : g_bad_cfg
      $error("blink_tick_gen: slowest period must be >= 2 and DEBOUNCE_CYCLES >= 2");
    end
  endgenerate

  logic              press_set;
  logic              press;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [31:0]       period_m1;
  logic              at_wrap;

  blink_tick_gen_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk_i      (CLOCK_50),
    .rst_i      (RESET),
    .key_n_i    (bus.KEY_N),
    .press_set_o(press_set),
    .press_o    (press)
  );

  // A rate change restarts the period and swallows any tick due on that edge.
  always_comb begin
    rate_d = rate_q;
    if (press_set) begin
      rate_d = (rate_q == RATE_LAST) ? '0 : rate_q + RATE_W'(1);
    end
    period_m1 = (32'(CLK_HZ) >> rate_q) - 32'd1;
    at_wrap   = (32'(cnt_q) == period_m1);
    cnt_d     = cnt_q + CNT_W'(1);
    tick_d    = 1'b0;
    if (press_set) begin
      cnt_d = '0;
    end else if (at_wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      rate_q <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      rate_q <= rate_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign bus.TICK     = tick_q;
  assign bus.PRESS    = press;
  assign bus.RATE_SEL = rate_q;

endmodule

// File: tb/tb_blink_tick_gen.sv
// Self-checking bench for blink_tick_gen: directed scenarios plus random key
// activity, compared each cycle against a run-length / elapsed-time model.
module tb_blink_tick_gen;

  localparam int CLK_HZ = 16;
  localparam int DB     = 4;
  localparam int NR     = 4;

  logic CLOCK_50 = 1'b0;
  logic RESET    = 1'b1;

  blink_tick_gen_if #(.NUM_RATES(NR)) bus ();

  blink_tick_gen #(
    .CLK_HZ         (CLK_HZ),
    .DEBOUNCE_CYCLES(DB),
    .NUM_RATES      (NR)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .bus     (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: key samples reach the qualifier two edges late; a level
  // is accepted after DB+1 consecutive samples differing from the accepted one.
  bit dly[$];
  bit accepted;
  int run_len;
  int m_rate;
  int anchor;
  bit exp_tick, exp_press;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit key, input bit rst);
    bit seen;
    bit changed;
    bus.KEY_N = key;
    RESET     = rst;
    @(posedge CLOCK_50);
    cyc++;
    exp_press = 1'b0;
    exp_tick  = 1'b0;
    changed   = 1'b0;
    if (rst) begin
      dly      = {1'b1, 1'b1};
      accepted = 1'b1;
      run_len  = 0;
      m_rate   = 0;
      anchor   = cyc;
    end else begin
      seen = dly.pop_front();
      dly.push_back(key);
      if (seen != accepted) begin
        run_len++;
        if (run_len == DB + 1) begin
          accepted = seen;
          run_len  = 0;
          if (!seen) begin
            exp_press = 1'b1;
            m_rate    = (m_rate + 1) % NR;
            changed   = 1'b1;
          end
        end
      end else begin
        run_len = 0;
      end
      if (changed) begin
        anchor = cyc;
      end else if (cyc - anchor == (CLK_HZ >> m_rate)) begin
        exp_tick = 1'b1;
        anchor   = cyc;
      end
    end
    #1;
    check("tick", 32'(bus.TICK), 32'(exp_tick));
    check("press", 32'(bus.PRESS), 32'(exp_press));
    check("rate_sel", 32'(bus.RATE_SEL), 32'(m_rate));
  endtask

  task automatic run(input bit key, input int n, output int n_press, output int first_press,
                     output int first_tick);
    n_press     = 0;
    first_press = -1;
    first_tick  = -1;
    for (int i = 0; i < n; i++) begin
      step(key, 1'b0);
      if (bus.PRESS === 1'b1) begin
        n_press++;
        if (first_press < 0) first_press = cyc;
      end
      if (bus.TICK === 1'b1 && first_tick < 0) first_tick = cyc;
    end
  endtask

  task automatic measure_period(output int per);
    int t0;
    t0  = -1;
    per = -1;
    for (int i = 0; i < 64; i++) begin
      if (per < 0) begin
        step(1'b1, 1'b0);
        if (bus.TICK === 1'b1) begin
          if (t0 < 0) t0 = cyc;
          else per = cyc - t0;
        end
      end
    end
  endtask

  task automatic press_release();
    int np, fp, ft;
    run(1'b0, 10, np, fp, ft);
    check("press_count", 32'(np), 32'd1);
    run(1'b1, 10, np, fp, ft);
  endtask

  int np, fp, ft, per, rst_cyc, fall, t_first, pcyc, ptick, next_tick, budget;
  int exp_rates[3]  = '{2, 3, 0};
  int exp_period[3] = '{4, 2, 16};

  initial begin
    bus.KEY_N = 1'b1;

    // 1: reset and base rate
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rst_cyc = cyc;
    check("rst_rate", 32'(bus.RATE_SEL), 32'd0);
    check("rst_tick", 32'(bus.TICK), 32'd0);
    check("rst_press", 32'(bus.PRESS), 32'd0);
    run(1'b1, 20, np, fp, t_first);
    check("s1_first_tick", 32'(t_first - rst_cyc), 32'd16);
    measure_period(per);
    check("s1_period", 32'(per), 32'd16);

    // 2: short glitch is rejected
    run(1'b0, 3, np, fp, ft);
    check("s2_glitch_press", 32'(np), 32'd0);
    run(1'b1, 20, np, fp, ft);
    check("s2_after_press", 32'(np), 32'd0);
    check("s2_rate", 32'(bus.RATE_SEL), 32'd0);
    measure_period(per);
    check("s2_period", 32'(per), 32'd16);

    // 3: long press, latency and new period
    fall = cyc + 1;
    run(1'b0, 20, np, fp, ft);
    check("s3_press_count", 32'(np), 32'd1);
    check("s3_latency", 32'(fp - fall), 32'd6);
    check("s3_rate", 32'(bus.RATE_SEL), 32'd1);
    run(1'b1, 12, np, fp, ft);
    measure_period(per);
    check("s3_period", 32'(per), 32'd8);

    // 4: step through the remaining rates and wrap
    for (int i = 0; i < 3; i++) begin
      press_release();
      check("s4_rate", 32'(bus.RATE_SEL), 32'(exp_rates[i]));
      measure_period(per);
      check("s4_period", 32'(per), 32'(exp_period[i]));
    end

    // 5: rate change on the edge where a rate-0 tick is due
    budget = 0;
    while (cyc - anchor != 9 && budget < 40) begin
      step(1'b1, 1'b0);
      budget++;
    end
    check("s5_align_budget", 32'(cyc - anchor), 32'd9);
    pcyc = -1; ptick = -1; next_tick = -1;
    for (int i = 0; i < 40; i++) begin
      step((i < 20) ? 1'b0 : 1'b1, 1'b0);
      if (bus.PRESS === 1'b1 && pcyc < 0) begin
        pcyc  = cyc;
        ptick = int'(bus.TICK);
      end else if (pcyc >= 0 && next_tick < 0 && bus.TICK === 1'b1) begin
        next_tick = cyc;
      end
    end
    check("s5_tick_at_change", 32'(ptick), 32'd0);
    check("s5_next_tick", 32'(next_tick - pcyc), 32'd8);

    // 6: reset while the key is held at rate 2
    press_release();
    check("s6_pre_rate", 32'(bus.RATE_SEL), 32'd2);
    run(1'b0, 10, np, fp, ft);
    step(1'b0, 1'b1);
    rst_cyc = cyc;
    check("s6_rst_rate", 32'(bus.RATE_SEL), 32'd0);
    check("s6_rst_tick", 32'(bus.TICK), 32'd0);
    check("s6_rst_press", 32'(bus.PRESS), 32'd0);
    run(1'b0, 12, np, fp, ft);
    check("s6_press_count", 32'(np), 32'd1);
    check("s6_latency", 32'(fp - (rst_cyc + 1)), 32'd6);
    check("s6_rate", 32'(bus.RATE_SEL), 32'd1);
    run(1'b1, 10, np, fp, ft);

    // Random key activity with occasional resets, checked by the model.
    for (int seg = 0; seg < 80; seg++) begin
      bit key;
      int len;
      key = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) begin
        step(key, ($urandom_range(0, 99) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
